// File: rtl/addr_mux.sv
// addr_mux: PC/IR address select for the shared bus, plus registered capture of address and source (ADDR_MUX_REG_OUT_EN registers addr_out).
// Latency: addr_out 0 cycles (1 when registered), addr_q/src_q/src_switch 1 cycle; hold freezes the capture and suppresses switch pulses.
module addr_mux #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic [ADDR_W-1:0] ir_addr,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              hold,
    output logic [ADDR_W-1:0] addr_out,
    output logic [ADDR_W-1:0] addr_q,
    output logic              src_q,
    output logic              src_switch
);

    logic [ADDR_W-1:0] mux;

    assign mux = sel ? ir_addr : pc_addr;

    // src_q resets to the PC source, so a first capture of IR reports a switch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            src_q      <= 1'b0;
            src_switch <= 1'b0;
        end else if (hold) begin
            src_switch <= 1'b0;
        end else begin
            addr_q     <= mux;
            src_q      <= sel;
            src_switch <= (sel != src_q);
        end
    end

`ifdef ADDR_MUX_REG_OUT_EN
    assign addr_out = addr_q;
`else
    assign addr_out = mux;
`endif

endmodule

// File: tb/tb_addr_mux.sv
// Directed bench for addr_mux: combinational select, capture/hold, switch pulses, async reset.
module tb_addr_mux;

    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              sel;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc_addr;
    logic              hold;
    logic [ADDR_W-1:0] addr_out;
    logic [ADDR_W-1:0] addr_q;
    logic              src_q;
    logic              src_switch;

    int n_checks = 0;
    int n_errors = 0;

    addr_mux #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .ir_addr    (ir_addr),
        .pc_addr    (pc_addr),
        .hold       (hold),
        .addr_out   (addr_out),
        .addr_q     (addr_q),
        .src_q      (src_q),
        .src_switch (src_switch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected addr_out given the hand-computed mux value and the expected addr_q.
    function automatic logic [ADDR_W-1:0] exp_out(input logic [ADDR_W-1:0] m, input logic [ADDR_W-1:0] q);
`ifdef ADDR_MUX_REG_OUT_EN
        return q;
`else
        return m;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [ADDR_W-1:0] q, input logic s, input logic sw);
        check({tag, ".addr_q"}, 32'(addr_q), 32'(q));
        check({tag, ".src_q"}, 32'(src_q), 32'(s));
        check({tag, ".src_switch"}, 32'(src_switch), 32'(sw));
    endtask

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        sel = 1'b0;
        ir_addr = '0;
        pc_addr = '0;
        #2;
        check_regs("reset", 5'b00000, 1'b0, 1'b0);

        // Combinational select while reset is held.
        sel = 1'b1; ir_addr = 5'b10110; pc_addr = 5'b00011;
        #10;
        check("comb_ir", 32'(addr_out), 32'(exp_out(5'b10110, 5'b00000)));
        sel = 1'b0;
        #1;
        check("comb_pc", 32'(addr_out), 32'(exp_out(5'b00011, 5'b00000)));
        sel = 1'b1; ir_addr = 5'b11111; pc_addr = 5'b00100;
        #1;
        check("comb_ir_all1", 32'(addr_out), 32'(exp_out(5'b11111, 5'b00000)));
        sel = 1'b0;
        #1;
        check("comb_pc2", 32'(addr_out), 32'(exp_out(5'b00100, 5'b00000)));
        tick();
        check_regs("edge_in_reset", 5'b00000, 1'b0, 1'b0);

        // First capture after release, IR source -> switch pulse.
        @(negedge clk);
        rst = 1'b0; hold = 1'b0; sel = 1'b1; ir_addr = 5'b10110; pc_addr = 5'b00011;
        tick();
        check_regs("cap1", 5'b10110, 1'b1, 1'b1);
        check("cap1.addr_out", 32'(addr_out), 32'(exp_out(5'b10110, 5'b10110)));
        tick();
        check_regs("cap2_same", 5'b10110, 1'b1, 1'b0);

        // Hold window: source change must not be seen until release.
        hold = 1'b1; sel = 1'b0; pc_addr = 5'b00011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_regs("held", 5'b10110, 1'b1, 1'b0);
            check("held.addr_out", 32'(addr_out), 32'(exp_out(5'b00011, 5'b10110)));
        end
        hold = 1'b0;
        tick();
        check_regs("unhold", 5'b00011, 1'b0, 1'b1);

        // Alternating source pulses every cycle, then stays low.
        sel = 1'b1; ir_addr = 5'b01010;
        tick();
        check_regs("alt1", 5'b01010, 1'b1, 1'b1);
        sel = 1'b0; pc_addr = 5'b10101;
        tick();
        check_regs("alt2", 5'b10101, 1'b0, 1'b1);
        tick();
        check_regs("alt3_same", 5'b10101, 1'b0, 1'b0);

        // Async reset between edges while addr_q = 11111.
        sel = 1'b1; ir_addr = 5'b11111;
        tick();
        check_regs("pre_rst", 5'b11111, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_regs("async_rst", 5'b00000, 1'b0, 1'b0);
        check("async_rst.addr_out", 32'(addr_out), 32'(exp_out(5'b11111, 5'b00000)));
        sel = 1'b0; pc_addr = 5'b00100;
        #1;
        check("rst_track.addr_out", 32'(addr_out), 32'(exp_out(5'b00100, 5'b00000)));
        hold = 1'b1;
        tick();
        check_regs("rst_over_hold", 5'b00000, 1'b0, 1'b0);

        // Release with IR selected: output waits for the edge in the registered build.
        @(negedge clk);
        rst = 1'b0; hold = 1'b0; sel = 1'b1; ir_addr = 5'b11111;
        #1;
        check("post_rst.addr_out", 32'(addr_out), 32'(exp_out(5'b11111, 5'b00000)));
        tick();
        check_regs("post_rst_cap", 5'b11111, 1'b1, 1'b1);
        check("post_rst_cap.addr_out", 32'(addr_out), 32'(exp_out(5'b11111, 5'b11111)));

        // First capture after reset with PC selected: no switch.
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0; sel = 1'b0; pc_addr = 5'b01100;
        tick();
        check_regs("post_rst_pc", 5'b01100, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
